// File: rtl/branch_predictor.sv
// Dynamic branch predictor: CTR_W-bit saturating direction counters plus a
// direct-mapped BTB (valid/tag/target), with a saturating misprediction
// counter. Fetch lookup is combinational from registered state; execute
// stage trains the tables on the rising edge.
// Optional macro BRANCH_PREDICTOR_GSHARE_EN: counter index = PC index XOR
// global history; BTB stays PC-indexed.
module branch_predictor #(
  parameter int DEPTH  = 64,
  parameter int CTR_W  = 2,
  parameter int TAG_W  = 8,
  parameter int HIST_W = 6,
  parameter int PERF_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [31:0]       PC_F,
  output logic              Predict_Taken_F,
  output logic [31:0]       Predict_Target_F,
  input  logic              Update_En_E,
  input  logic [31:0]       PC_E,
  input  logic              Branch_Taken_E,
  input  logic [31:0]       Branch_Target_E,
  input  logic              Predict_Taken_E,
  input  logic [31:0]       Predict_Target_E,
  output logic              Mispredict_E,
  output logic [PERF_W-1:0] Mispredict_Count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W-1));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W-1)) - 1);

  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0][TAG_W-1:0]  r_tag;
  logic [DEPTH-1:0][31:0]       r_tgt;
  logic [DEPTH-1:0][CTR_W-1:0]  r_ctr;
  logic [PERF_W-1:0]            r_cnt;

  logic [IDX_W-1:0] w_idx_f, w_idx_e, w_cidx_f, w_cidx_e;
  logic [TAG_W-1:0] w_tag_f, w_tag_e;
  logic             w_hit_f, w_hit_e;
  logic [CTR_W-1:0] w_ctr_e;
  logic             w_unused_ok;

  assign w_idx_f = PC_F[IDX_W+1:2];
  assign w_tag_f = PC_F[IDX_W+TAG_W+1:IDX_W+2];
  assign w_idx_e = PC_E[IDX_W+1:2];
  assign w_tag_e = PC_E[IDX_W+TAG_W+1:IDX_W+2];
  // Low PC bits and bits above the tag never take part in addressing.
  assign w_unused_ok = ^{PC_F, PC_E};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [HIST_W-1:0] r_ghr;
  logic [IDX_W-1:0]  w_ghr_idx;

  // History is truncated or zero-extended to the index width.
  if (HIST_W >= IDX_W) begin : g_ghr_trunc
    assign w_ghr_idx = r_ghr[IDX_W-1:0];
  end else begin : g_ghr_ext
    assign w_ghr_idx = {{(IDX_W-HIST_W){1'b0}}, r_ghr};
  end

  assign w_cidx_f = w_idx_f ^ w_ghr_idx;
  assign w_cidx_e = w_idx_e ^ w_ghr_idx;

  // Non-speculative global history: shifts in each resolved outcome.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)           r_ghr <= '0;
    else if (Update_En_E) r_ghr <= HIST_W'({r_ghr, Branch_Taken_E});
  end
`else
  assign w_cidx_f = w_idx_f;
  assign w_cidx_e = w_idx_e;
`endif

  // Fetch lookup: zero latency, sees pre-update state in an update cycle.
  assign w_hit_f          = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
  assign Predict_Taken_F  = w_hit_f && r_ctr[w_cidx_f][CTR_W-1];
  assign Predict_Target_F = Predict_Taken_F ? r_tgt[w_idx_f] : PC_F + 32'd4;

  assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
  assign w_ctr_e = r_ctr[w_cidx_e];

  assign Mispredict_E = Update_En_E &&
                        ((Predict_Taken_E != Branch_Taken_E) ||
                         (Branch_Taken_E && (Predict_Target_E != Branch_Target_E)));

  // Table training: hits move the counter, taken misses allocate the entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_valid <= '0;
      r_tag   <= '0;
      r_tgt   <= '0;
      r_ctr   <= {DEPTH{CTR_WNT}};
    end else if (Update_En_E) begin
      if (w_hit_e) begin
        if (Branch_Taken_E) begin
          r_tgt[w_idx_e] <= Branch_Target_E;
          if (w_ctr_e != CTR_MAX) r_ctr[w_cidx_e] <= w_ctr_e + CTR_W'(1);
        end else if (w_ctr_e != '0) begin
          r_ctr[w_cidx_e] <= w_ctr_e - CTR_W'(1);
        end
      end else if (Branch_Taken_E) begin
        r_valid[w_idx_e] <= 1'b1;
        r_tag[w_idx_e]   <= w_tag_e;
        r_tgt[w_idx_e]   <= Branch_Target_E;
        r_ctr[w_cidx_e]  <= CTR_WT;
      end
    end
  end

  // Misprediction counter saturates instead of wrapping.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                              r_cnt <= '0;
    else if (Mispredict_E && (r_cnt != '1))  r_cnt <= r_cnt + PERF_W'(1);
  end

  assign Mispredict_Count = r_cnt;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor: direction table of CTR_W-bit saturating counters plus a direct-mapped branch target buffer (BTB).
- Fetch stage looks it up combinationally each cycle; execute stage trains it with resolved branch outcomes.
- Generalises the fixed 2-bit STRONGLY_UNTAKEN..STRONGLY_TAKEN scheme to arbitrary depth and counter width, and adds target prediction and a misprediction counter.

Parameters:
DEPTH, 64, entries in counter table and BTB; power of 2, >= 2; IDX_W = log2(DEPTH)
CTR_W, 2, saturating counter width, 1..4
TAG_W, 8, BTB tag width; IDX_W+TAG_W+2 <= 32
HIST_W, 6, global history width, used only with GSHARE_EN
PERF_W, 16, misprediction counter width

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
PC_F  in  32  fetch-stage PC
Predict_Taken_F  out  1  PREDICT_TAKEN/PREDICT_NOT_TAKEN for PC_F
Predict_Target_F  out  32  predicted next PC for PC_F
Update_En_E  in  1  resolved conditional branch or jump in execute this cycle
PC_E  in  32  PC of the resolved branch
Branch_Taken_E  in  1  BRANCH_TAKEN/BRANCH_NOT_TAKEN outcome
Branch_Target_E  in  32  resolved target address
Predict_Taken_E  in  1  prediction originally made for this branch, piped down
Predict_Target_E  in  32  target originally predicted, piped down
Mispredict_E  out  1  combinational: the current update is a misprediction
Mispredict_Count  out  PERF_W  saturating count of mispredictions

Behaviour:
- Address fields: index = PC[IDX_W+1:2]; tag = PC[IDX_W+TAG_W+1:IDX_W+2].
- State per entry: valid bit, tag, 32-bit target, CTR_W counter.
- Lookup is combinational from registered state, with zero latency.
  - hit = valid && tag match.
  - Predict_Taken_F = hit && counter MSB.
  - Predict_Target_F = stored target when Predict_Taken_F, else PC_F+4 (mod 2^32).
- Updates occur on the rising edge when Update_En_E=1. They are visible to lookups from the next cycle.
  - No same-cycle bypass: a lookup to the index being updated returns the old value.
- Update on hit:
  - Taken: counter increments, saturating at 2^CTR_W-1; target is overwritten with Branch_Target_E.
  - Not taken: counter decrements, saturating at 0; target is unchanged.
- Update on miss:
  - Taken: allocate (overwrite) the entry. Valid=1, tag=PC_E tag, target=Branch_Target_E, counter = weakly taken = 2^(CTR_W-1).
  - Not taken: no state change.
- Mispredict_E = Update_En_E && ((Predict_Taken_E != Branch_Taken_E) || (Branch_Taken_E && Predict_Target_E != Branch_Target_E)).
- Mispredict_Count increments on each edge where Mispredict_E=1. It saturates at 2^PERF_W-1 and never wraps.
- CTR_W=1 degenerates to a last-outcome bit: taken-allocate sets it to 1.
- Reset (asynchronous, any time, including mid-update):
  - All valid bits 0; all counters = weakly untaken = 2^(CTR_W-1)-1 (0 when CTR_W=1); tags and targets 0.
  - Mispredict_Count = 0; history = 0.
  - Outputs during reset: Predict_Taken_F=0, Predict_Target_F=PC_F+4, Mispredict_E follows its inputs.
- Update_En_E=0: no state changes.

Optional Feature:
- Macro: BRANCH_PREDICTOR_GSHARE_EN.
- Defined:
  - A HIST_W-bit global history register (GHR) shifts left on each update, inserting Branch_Taken_E at bit 0.
  - Counter index = PC index XOR GHR, with GHR zero-extended or truncated to IDX_W. The same current (non-speculative) GHR is used for both lookup and update.
  - BTB valid, tag and target remain indexed by PC index only.
  - On an update, the counter at the pre-shift GHR index is modified, then the GHR shifts.
- Undefined: no GHR; counter index = PC index. HIST_W is ignored.

Test Plan:
- Reset, PC_F=0x100 -> Predict_Taken_F=0, Predict_Target_F=0x104, Mispredict_Count=0.
- Update PC_E=0x100 taken to 0x200, Predict_Taken_E=0 -> Mispredict_E=1 and count=1. Next cycle, PC_F=0x100 gives Predict_Taken_F=1, Predict_Target_F=0x200, counter=2.
- Three more taken updates at 0x100 -> counter saturates at 3. Two not-taken updates -> counter=1, Predict_Taken_F=0, Predict_Target_F=0x104.
- Aliasing (DEPTH=64): after 0x100 is allocated, PC_F=0x4100 (same index, different tag) -> miss, not taken. Taken update at 0x4100 to 0x500 evicts 0x100; PC_F=0x100 then misses.
- Simultaneous lookup/update at 0x100 in the same cycle -> lookup shows pre-update value. Assert RST_N low mid-update -> all entries invalid immediately, count=0.
- Force PERF_W=4 and apply 20 mispredicting updates -> Mispredict_Count holds at 15. With BRANCH_PREDICTOR_GSHARE_EN, alternating T/N at one PC converges to correct predictions after warm-up.
